ucca_multi_region: RTL

Parametrised successor to the single-region UCCA monitor. It watches the program counter against NUM_REGIONS independently configured untrusted-code (UCC) regions and enforces entry-point-only entry into each region. It keeps a return-address stack so that nested calls between regions must unwind in LIFO order, and treats interrupts inside any region as a violation. A violation raises a sticky reset toward the core that holds until the core fetches RESET_HANDLER.

---
 rtl/ucca_pkg.sv | 23 ++
 rtl/ucca_ra_stack.sv | 51 +++++
 rtl/ucca_multi_region.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/ucca_pkg.sv
// rtl/ucca_pkg.sv - shared cause codes, FSM encoding and return-stack entry type for the UCCA monitor
package ucca_pkg;

  localparam logic [2:0] CAUSE_NONE     = 3'd0;
  localparam logic [2:0] CAUSE_ENTRY    = 3'd1;
  localparam logic [2:0] CAUSE_RETURN   = 3'd2;
  localparam logic [2:0] CAUSE_IRQ      = 3'd3;
  localparam logic [2:0] CAUSE_OVERFLOW = 3'd4;

  // Wide enough for region ids up to 8 regions plus the NONE code.
  localparam int RID_FIELD_W = 4;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_VIOL = 1'b1
  } state_t;

  typedef struct packed {
    logic [15:0]            ret_addr;
    logic [RID_FIELD_W-1:0] caller_region;
  } ra_entry_t;

endpackage

// File: rtl/ucca_ra_stack.sv
// rtl/ucca_ra_stack.sv - synchronous LIFO of return-address entries with push/pop/clear
module ucca_ra_stack
  import ucca_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          system_reset,
  input  logic          clear,
  input  logic          push,
  input  logic          pop,
  input  ra_entry_t     push_data,
  output ra_entry_t     top,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int PW = $clog2(DEPTH);

  ra_entry_t       mem [DEPTH];
  logic [CW-1:0]   cnt;
  logic [PW-1:0]   wr_idx;
  logic [PW-1:0]   top_idx;

  assign wr_idx  = cnt[PW-1:0];
  assign top_idx = wr_idx - PW'(1);
  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign top     = empty ? '0 : mem[top_idx];

  always_ff @(posedge clk) begin
    if (system_reset || clear) begin
      cnt <= '0;
    end else if (push && !full) begin
      cnt <= cnt + CW'(1);
    end else if (pop && !empty) begin
      cnt <= cnt - CW'(1);
    end
  end

  // Storage is not reset; an empty stack masks stale contents through top.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_idx] <= push_data;
    end
  end

endmodule

// File: rtl/ucca_multi_region.sv
// rtl/ucca_multi_region.sv - multi-region untrusted-code monitor with entry-point and LIFO return enforcement
module ucca_multi_region
  import ucca_pkg::*;
#(
  parameter int          NUM_REGIONS   = 4,
  parameter int          RA_DEPTH      = 8,
  parameter logic [15:0] RESET_HANDLER = 16'h0000,
  parameter int          RID_W         = $clog2(NUM_REGIONS + 1)
) (
  input  logic                          clk,
  input  logic                          system_reset,
  input  logic [15:0]                   pc,
  input  logic                          irq_jmp,
  input  logic [15:0]                   ret_addr_in,
  input  logic [NUM_REGIONS-1:0]        ucc_en,
  input  logic [16*NUM_REGIONS-1:0]     ucc_min,
  input  logic [16*NUM_REGIONS-1:0]     ucc_max,
  output logic                          reset,
  output logic [2:0]                    violation_cause,
  output logic [RID_W-1:0]              cur_region,
  output logic [$clog2(RA_DEPTH+1)-1:0] ra_depth,
  output logic [15:0]                   return_address
);

  localparam int               DW       = $clog2(RA_DEPTH + 1);
  localparam logic [RID_W-1:0] RID_NONE = RID_W'(NUM_REGIONS);

  state_t           state, state_next;
  logic [2:0]       cause, cause_next;
  logic [RID_W-1:0] cur, cur_next;
  logic [RID_W-1:0] hit_id;
  logic             hit_at_min;

  logic             push, pop, clear;
  logic             push_req, pop_req;
  logic             in_region, legal_ret;
  logic             irq_v, ovf_v, entry_v, ret_v;
  ra_entry_t        push_entry, top_entry;
  logic             st_full, st_empty;
  logic [DW-1:0]    st_count;

  // Lowest-numbered enabled region containing pc wins.
  always_comb begin
    hit_id     = RID_NONE;
    hit_at_min = 1'b0;
    for (int k = NUM_REGIONS - 1; k >= 0; k--) begin
      if (ucc_en[k] && pc >= ucc_min[16*k +: 16] && pc <= ucc_max[16*k +: 16]) begin
        hit_id     = RID_W'(k);
        hit_at_min = (pc == ucc_min[16*k +: 16]);
      end
    end
  end

  assign push_entry.ret_addr      = ret_addr_in;
  assign push_entry.caller_region = RID_FIELD_W'(cur);

  assign in_region = (cur != RID_NONE);
  assign legal_ret = !st_empty && (pc == top_entry.ret_addr)
                     && (hit_id == RID_W'(top_entry.caller_region));

  always_comb begin
    state_next = state;
    cause_next = cause;
    cur_next   = cur;
    push       = 1'b0;
    pop        = 1'b0;
    clear      = 1'b0;
    push_req   = 1'b0;
    pop_req    = 1'b0;
    irq_v      = 1'b0;
    ovf_v      = 1'b0;
    entry_v    = 1'b0;
    ret_v      = 1'b0;
    case (state)
      ST_RUN: begin
        irq_v = irq_jmp && in_region;
        if (hit_id != cur) begin
          if (in_region && legal_ret) begin
            pop_req = 1'b1;
          end else if (hit_id != RID_NONE && hit_at_min) begin
            push_req = 1'b1;
          end else if (in_region) begin
            ret_v = 1'b1;
          end else begin
            entry_v = 1'b1;
          end
        end
        ovf_v = push_req && st_full;
        // Any violation freezes the stack and region tracking as they were.
        if (irq_v) begin
          state_next = ST_VIOL;
          cause_next = CAUSE_IRQ;
        end else if (ovf_v) begin
          state_next = ST_VIOL;
          cause_next = CAUSE_OVERFLOW;
        end else if (entry_v) begin
          state_next = ST_VIOL;
          cause_next = CAUSE_ENTRY;
        end else if (ret_v) begin
          state_next = ST_VIOL;
          cause_next = CAUSE_RETURN;
        end else if (push_req) begin
          push     = 1'b1;
          cur_next = hit_id;
        end else if (pop_req) begin
          pop      = 1'b1;
          cur_next = RID_W'(top_entry.caller_region);
        end
      end
      ST_VIOL: begin
        if (pc == RESET_HANDLER) begin
          state_next = ST_RUN;
          cause_next = CAUSE_NONE;
          cur_next   = RID_NONE;
          clear      = 1'b1;
        end
      end
      default: state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (system_reset) begin
      state <= ST_RUN;
      cause <= CAUSE_NONE;
      cur   <= RID_NONE;
    end else begin
      state <= state_next;
      cause <= cause_next;
      cur   <= cur_next;
    end
  end

  ucca_ra_stack #(
    .DEPTH (RA_DEPTH),
    .CW    (DW)
  ) u_stack (
    .clk          (clk),
    .system_reset (system_reset),
    .clear        (clear),
    .push         (push),
    .pop          (pop),
    .push_data    (push_entry),
    .top          (top_entry),
    .count        (st_count),
    .full         (st_full),
    .empty        (st_empty)
  );

  assign reset           = (state == ST_VIOL);
  assign violation_cause = cause;
  assign cur_region      = cur;
  assign ra_depth        = st_count;
  assign return_address  = top_entry.ret_addr;

endmodule
